// File: rtl/scatter_1to16_clk.sv
// scatter_1to16_clk
// Scatters single data words into a 16-lane vector. Each accepted word is
// written to the lane named by in_sel. Select values 16..31 are the null lane.
// The vector is released once all lanes are written, or earlier on flush.
// While it is held, the consumer drains it with out_ready.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_FILL | accepting words (in_ready=1); vector is being assembled
// ST_HOLD | vector presented (out_valid=1); inputs stalled until out_ready
module scatter_1to16_clk #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [4:0]            in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out_vec [15:0],
    output logic [15:0]           out_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            drop_cnt
);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_vec [15:0];
    logic [15:0]           r_mask;
    logic [7:0]            r_drop;

    logic                  w_xfer;
    logic                  w_lane_wr;
    logic                  w_null_wr;
    logic [15:0]           w_lane_onehot;
    logic [15:0]           w_mask_next;
    logic                  w_mask_full;
    logic                  w_flush_go;

    // Handshake flags come straight from the state register, with no input term.
    assign in_ready  = (r_state == ST_FILL);
    assign out_valid = (r_state == ST_HOLD);
    assign out_vec   = r_vec;
    assign out_mask  = r_mask;
    assign drop_cnt  = r_drop;

    // Classify this cycle's transfer and preview the mask after its write.
    always_comb begin
        w_xfer        = in_valid & in_ready;
        w_lane_wr     = w_xfer & ~in_sel[4];
        w_null_wr     = w_xfer &  in_sel[4];
        w_lane_onehot = '0;
        if (w_lane_wr) begin
            w_lane_onehot = 16'h0001 << in_sel[3:0];
        end
        w_mask_next   = r_mask | w_lane_onehot;
        w_mask_full   = (w_mask_next == 16'hFFFF);
        // Flush on an empty vector is ignored so that an all-null vector is never emitted.
        w_flush_go    = flush & (w_mask_next != 16'h0000);
    end

    // Fill/hold sequencing with the lane vector and mask it owns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FILL;
            r_vec   <= '{default: '0};
            r_mask  <= '0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_lane_wr) begin
                        r_vec[in_sel[3:0]] <= in_data;
                    end
                    r_mask <= w_mask_next;
                    if (w_mask_full || w_flush_go) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // On release, clearing every lane keeps unwritten lanes at zero in the next fill.
                    if (out_ready) begin
                        r_vec   <= '{default: '0};
                        r_mask  <= '0;
                        r_state <= ST_FILL;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

    // Saturating count of words sent to the null lane. Only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop <= '0;
        end else if (w_null_wr && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

endmodule

// File: doc/scatter_1to16_clk.md
SCATTER_1TO16_CLK -- requirements
Module: scatter_1to16_clk

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, default 8, lane data width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_data  input  DATA_WIDTH  value to scatter.
REQ-005 SHALL have port: in_sel  input  5  destination lane; 0..15 valid lanes, 16..31 null lane.
REQ-006 SHALL have port: in_valid  input  1  in_data/in_sel valid.
REQ-007 SHALL have port: in_ready  output  1  block accepts input this cycle.
REQ-008 SHALL have port: flush  input  1  request early release of a partially filled vector.
REQ-009 SHALL have port: out_vec  output  [DATA_WIDTH-1:0] x16 unpacked [15:0]  assembled lane vector, registered.
REQ-010 SHALL have port: out_mask  output  16  bit i set = lane i written since last release.
REQ-011 SHALL have port: out_valid  output  1  out_vec/out_mask valid.
REQ-012 SHALL have port: out_ready  input  1  consumer accepts vector.
REQ-013 SHALL have port: drop_cnt  output  8  count of null-lane transfers, saturating.

Function
REQ-014 SHALL implement two states: FILL (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1), both decoded from registered state only.
REQ-015 SHALL define an input transfer as in_valid & in_ready at a rising clk edge.
REQ-016 SHALL, on a transfer with in_sel in 0..15, write in_data to out_vec[in_sel] and set out_mask[in_sel] at that edge; result visible the following cycle.
REQ-017 SHALL, on repeated transfers to the same lane within one fill, keep the last value (last-write-wins); mask bit stays set.
REQ-018 SHALL, on a transfer with in_sel in 16..31, discard in_data, leave out_vec/out_mask unchanged, and increment drop_cnt, holding at 255.
REQ-019 SHALL transition FILL->HOLD at the edge where out_mask becomes 16'hFFFF after that edge's write.
REQ-020 SHALL transition FILL->HOLD at an edge with flush=1 when out_mask after that edge's write is nonzero; a same-edge write is included in the held vector.
REQ-021 SHALL ignore flush when out_mask after that edge's write would be zero (remain in FILL) and ignore flush in HOLD.
REQ-022 SHALL hold out_vec/out_mask stable throughout HOLD, regardless of in_valid, in_sel or flush.
REQ-023 SHALL, in HOLD at an edge with out_ready=1, clear all out_vec lanes to 0, clear out_mask to 0, and return to FILL; in_ready rises the next cycle.
REQ-024 SHALL keep every unwritten lane of out_vec at 0 (the null value).
REQ-025 SHALL ignore out_ready in FILL.
REQ-026 SHALL not clear drop_cnt except on reset.

Reset
REQ-027 SHALL, while reset=0, asynchronously force state FILL, out_vec all 0, out_mask 0, drop_cnt 0, hence in_ready=1, out_valid=0.
REQ-028 SHALL discard a partially filled or held vector when reset asserts mid-operation; no transfer completes at the edge where reset is low.
REQ-029 SHALL resume normal operation at the first rising clk edge after reset deasserts.

Verification
REQ-030 Bench SHALL cover full fill: 16 transfers, in_sel 0..15, in_data 8'h10+i, out_ready=0 -> out_valid=1 the cycle after the 16th transfer, out_mask=16'hFFFF, out_vec[i]=8'h10+i, in_ready=0.
REQ-031 Bench SHALL cover flush with a same-edge write: writes lane 3=8'hA5, then lane 7=8'h5A with flush=1 on the same edge -> HOLD, out_mask=16'h0088, all other lanes 0; flush with empty mask -> stays FILL.
REQ-032 Bench SHALL cover overwrite and null lane: lane 2=8'h11, lane 2=8'h22, in_sel=16 data 8'hFF, in_sel=31 -> out_vec[2]=8'h22, out_mask=16'h0004, drop_cnt=2; 300 null transfers -> drop_cnt=255.
REQ-033 Bench SHALL cover backpressure: in HOLD, out_ready=0 for 5 cycles with in_valid=1 -> outputs stable, no transfers; out_ready=1 -> next cycle out_valid=0, in_ready=1, out_mask=0.
REQ-034 Bench SHALL cover reset mid-operation: reset=0 asynchronously after 9 lanes written -> immediately out_mask=0, out_vec all 0, drop_cnt=0, in_ready=1; a fresh fill after release behaves per REQ-030.
